ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Receive-only PS/2 keyboard front end: oversamples the open-collector PS/2 clock/data pair on `clk_sys`, deframes 11-bit device-to-host frames, and interprets Set 2 prefix bytes (E0 extended, F0 break, E1 pause). Emits one-cycle key events (`key_strobe`, `key_pressed`, `key_code`) that feed the TI-99/4A keyboard matrix block directly. Host-to-device transmission (LED and reset commands) is out of scope; the block never drives the PS/2 lines.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical `clk_sys` samples required before a filtered PS/2 line changes level (range 2..255).
- `TIMEOUT_CYCLES`, 100000: `clk_sys` cycles without a filtered `ps2_clk` falling edge before a partial frame is discarded (range 16..2^20-1).

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock line, asynchronous.
- `ps2_data` in 1: raw PS/2 data line, asynchronous.
- `key_strobe` out 1: one-cycle pulse per decoded key event.
- `key_pressed` out 1: 1 = make, 0 = break; valid with the strobe and held until the next strobe.
- `key_code` out 8: Set 2 scan code without prefixes; held until the next strobe.
- `key_extended` out 1: event was E0-prefixed; held until the next strobe.
- `frame_err` out 1: one-cycle pulse on a start, parity or stop error, or on a timeout.

## Operation
- Input stage: 2-flop synchronizer per line, then a saturating counter filter of `FILTER_LEN` samples. A falling-edge detector on filtered `ps2_clk` produces `fall`.
- Frame FSM, sampling filtered data on `fall`:
  - IDLE: data 0 goes to DATA with bit count 0; data 1 raises `frame_err` and stays in IDLE.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP: require stop bit 1 and odd parity over the 8 data bits plus the parity bit. On success assert internal `byte_valid` with the byte. On failure raise `frame_err`. Go to IDLE in both cases.
- Watchdog: a counter is cleared on every `fall` and counts only while not in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and pulses `frame_err`.
- Scan-code decoder, evaluated on `byte_valid`:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - E1 loads `skip` = 7; while `skip` is nonzero, each byte only decrements `skip`.
  - AA and FA are discarded.
  - Any other byte asserts `key_strobe` with `key_code` = byte, `key_pressed` = ~`brk`, `key_extended` = `ext`, then clears `ext` and `brk`.
- `frame_err` also clears `ext`, `brk` and `skip`, so a corrupted prefix never attaches to a later code.

## Timing
- Reset values: all outputs 0, frame FSM in IDLE, filters preset to 1 (idle bus), `ext`, `brk` and `skip` cleared, watchdog 0.
- Filtered line delay: 2 sync cycles + `FILTER_LEN` cycles after a stable raw level.
- `key_strobe` is asserted exactly 1 cycle after the `fall` that samples the stop bit, and lasts 1 cycle. Each frame yields at most one strobe. Minimum spacing between strobes is one PS/2 frame.
- `frame_err` has the same latency as `key_strobe` relative to the failing `fall`. On timeout it pulses on the cycle the count reaches `TIMEOUT_CYCLES`.
- If `fall` and a timeout occur in the same cycle, `fall` wins and the watchdog clears.
- Reset asserted mid-frame: state is cleared immediately. The next falling edge must carry a valid start bit or is reported as an error after reset deasserts.

## Configuration
- `PS2_RX_TYPEMATIC_FILTER_EN` defined: a last-make register (code plus ext, with a valid bit) suppresses repeated make events with an identical code and ext flag. Any break event, or a make with a different code, updates or clears the register. Break events are never suppressed.
- `PS2_RX_TYPEMATIC_FILTER_EN` undefined: every typematic repeat produces a make strobe. Toggle-style consumers (alpha lock) must then tolerate repeats.

## Structure
- Package `ps2_pkg`: the frame FSM state enum, the prefix constants (`PS2_E0`, `PS2_F0`, `PS2_E1`, `PS2_BAT_OK` = AA, `PS2_ACK` = FA) and the E1 skip length of 7.
- Sub-module `ps2_line_filter`: synchronizer plus counter filter, parameterized by `FILTER_LEN`, instantiated once per line. The frame FSM, watchdog and decoder stay in the top module.

## Test plan
- Frame 0x1C (A) with correct parity, then F0 and 0x1C -> a strobe with code 1C, pressed=1, ext=0, then a strobe with code 1C, pressed=0, ext=0; `frame_err` stays low.
- Sequence E0 75, then E0 F0 75 -> a strobe with code 75, pressed=1, ext=1, then a strobe with code 75, pressed=0, ext=1; the prefix bytes produce no strobe.
- Frame 0x16 with parity flipped, then 0x16 valid -> one `frame_err` pulse, then exactly one strobe with code 16, pressed=1.
- Start bit and 4 data bits, then an idle gap longer than `TIMEOUT_CYCLES`, then frame 0x29 -> `frame_err` pulses after the timeout, then a strobe with code 29.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x5A -> no strobes during the sequence, then a strobe with code 5A, pressed=1.
- With `PS2_RX_TYPEMATIC_FILTER_EN`: 0x1C sent three times, then F0 1C, then 0x1C -> strobes are make, break, make; without the macro -> make ×3, break, make.

Source files
------------

// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module  : ps2_pkg
// Brief   : Shared types and Set 2 prefix constants for the PS/2 receiver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_E0      = 8'hE0;
  localparam logic [7:0] PS2_F0      = 8'hF0;
  localparam logic [7:0] PS2_E1      = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [2:0] PS2_E1_SKIP = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
//------------------------------------------------------------------------------
// Module  : ps2_line_filter
// Brief   : Two-flop synchronizer plus saturating-count glitch filter, idle high.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam logic [7:0] C_CNT_LAST = 8'(FILTER_LEN - 1);

  logic       r_sync0;
  logic       r_sync1;
  logic       r_filt;
  logic [7:0] r_cnt;

  // Output flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_filt <= r_sync1;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
//------------------------------------------------------------------------------
// Module  : ps2_keyboard_rx
// Brief   : Receive-only PS/2 keyboard deframer and Set 2 prefix decoder.
//           Option macro: PS2_RX_TYPEMATIC_FILTER_EN (suppress repeated makes).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       frame_err
);

  localparam logic [19:0] C_WDOG_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic         w_clk_f;
  logic         w_data_f;
  logic         r_clk_prev;
  logic         w_fall;

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic [2:0]   r_bitcnt;
  logic [7:0]   r_shift;
  logic         r_par;
  logic [19:0]  r_wdog;
  logic         w_byte_valid;
  logic         w_err;
  logic         w_timeout;

  logic         r_ext;
  logic         r_brk;
  logic [2:0]   r_skip;
  logic         w_key_evt;
  logic         w_suppress;

  logic         r_key_strobe;
  logic         r_key_pressed;
  logic [7:0]   r_key_code;
  logic         r_key_ext;
  logic         r_frame_err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk_sys),
    .rst    (reset),
    .i_raw  (ps2_clk),
    .o_filt (w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk_sys),
    .rst    (reset),
    .i_raw  (ps2_data),
    .o_filt (w_data_f)
  );

  assign w_fall = r_clk_prev & ~w_clk_f;

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_valid = 1'b0;
    w_err        = 1'b0;
    w_timeout    = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_data_f) w_state_nxt = ST_DATA;
          else           w_err       = 1'b1;
        end
        ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (w_data_f && (^{r_shift, r_par})) w_byte_valid = 1'b1;
          else                                 w_err        = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_wdog == C_WDOG_LAST) begin
      w_timeout   = 1'b1;
      w_err       = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_prev <= 1'b1;
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_clk_prev <= w_clk_f;
      r_state    <= w_state_nxt;
      if (w_fall || w_timeout || r_state == ST_IDLE) r_wdog <= '0;
      else                                          r_wdog <= r_wdog + 20'd1;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: r_bitcnt <= '0;
          ST_DATA: begin
            r_shift  <= {w_data_f, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          ST_PARITY: r_par <= w_data_f;
          default: ;
        endcase
      end
    end
  end

  assign w_key_evt = w_byte_valid && (r_skip == 3'd0) &&
                     (r_shift != PS2_E0) && (r_shift != PS2_F0) &&
                     (r_shift != PS2_E1) && (r_shift != PS2_BAT_OK) &&
                     (r_shift != PS2_ACK);

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic       r_lm_valid;
  logic       r_lm_ext;
  logic [7:0] r_lm_code;

  assign w_suppress = ~r_brk && r_lm_valid && (r_lm_code == r_shift) && (r_lm_ext == r_ext);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_lm_valid <= 1'b0;
      r_lm_ext   <= 1'b0;
      r_lm_code  <= '0;
    end else if (w_key_evt) begin
      if (r_brk) begin
        r_lm_valid <= 1'b0;
      end else begin
        r_lm_valid <= 1'b1;
        r_lm_ext   <= r_ext;
        r_lm_code  <= r_shift;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_skip        <= '0;
      r_key_strobe  <= 1'b0;
      r_key_pressed <= 1'b0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_key_strobe <= 1'b0;
      r_frame_err  <= w_err;
      // An error drops any pending prefix so it cannot attach to a later code.
      if (w_err) begin
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
        r_skip <= '0;
      end else if (w_byte_valid) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_shift == PS2_E0) begin
          r_ext <= 1'b1;
        end else if (r_shift == PS2_F0) begin
          r_brk <= 1'b1;
        end else if (r_shift == PS2_E1) begin
          r_skip <= PS2_E1_SKIP;
        end else if (w_key_evt) begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!w_suppress) begin
            r_key_strobe  <= 1'b1;
            r_key_pressed <= ~r_brk;
            r_key_code    <= r_shift;
            r_key_ext     <= r_ext;
          end
        end
      end
    end
  end

  assign key_strobe   = r_key_strobe;
  assign key_pressed  = r_key_pressed;
  assign key_code     = r_key_code;
  assign key_extended = r_key_ext;
  assign frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_ps2_keyboard_rx
// Brief   : Self-checking bench: directed and random PS/2 frames vs. byte model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

  localparam int FILT = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe;
  logic       key_pressed;
  logic [7:0] key_code;
  logic       key_extended;
  logic       frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .key_extended (key_extended),
    .frame_err    (frame_err)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0;
  int  cyc = 0, stop_cyc = 0;
  int  obs_err = 0, exp_err = 0, obs_strobes = 0, exp_strobes = 0;
  bit  m_ext = 0, m_brk = 0;
  int  m_skip = 0;
  bit  lm_valid = 0, lm_ext = 0;
  logic [7:0] lm_code = '0;
  logic prev_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (frame_err) obs_err++;
    if (key_strobe) begin
      obs_strobes++;
      chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
      chk("strobe_latency", cyc - stop_cyc, FILT + 3);
      chk("strobe_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("key_code", {24'd0, key_code}, {24'd0, e.code});
        chk("key_pressed", {31'd0, key_pressed}, {31'd0, e.pressed});
        chk("key_extended", {31'd0, key_extended}, {31'd0, e.ext});
      end
    end
    prev_strobe = key_strobe;
  end

  // Reference: Set 2 byte-stream interpretation at the event level.
  task automatic model_byte(input logic [7:0] b);
    bit sup;
    sup = 0;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hAA || b == 8'hFA) begin end
    else begin
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
      sup = !m_brk && lm_valid && lm_code == b && lm_ext == m_ext;
      if (m_brk) lm_valid = 0;
      else begin lm_valid = 1; lm_code = b; lm_ext = m_ext; end
`endif
      if (!sup) begin
        exp_q.push_back(ev_t'{b, ~m_brk, m_ext});
        exp_strobes++;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk  = 1'b0;
      stop_cyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err++;
      model_clear();
    end else begin
      model_byte(b);
    end
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b0);
  endtask

  task automatic checkpoint(input string tag);
    repeat (10) @(negedge clk_sys);
    chk({tag, "_errs"}, obs_err, exp_err);
    chk({tag, "_strobes"}, obs_strobes, exp_strobes);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_strobe"}, {31'd0, key_strobe}, 0);
    chk({tag, "_pressed"}, {31'd0, key_pressed}, 0);
    chk({tag, "_code"}, {24'd0, key_code}, 0);
    chk({tag, "_ext"}, {31'd0, key_extended}, 0);
    chk({tag, "_err"}, {31'd0, frame_err}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] b;
    int r;
    repeat (5) @(negedge clk_sys);
    chk_outputs_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);

    send_seq('{8'h1C, 8'hF0, 8'h1C});
    checkpoint("make_break_A");

    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    checkpoint("extended");

    send_byte(8'h16, 1'b1);
    send_byte(8'h16, 1'b0);
    checkpoint("parity_err");

    send_bits(11'b000_0000_1010, 5);
    repeat (TMO + 500) @(negedge clk_sys);
    exp_err++;
    model_clear();
    chk("timeout_errs", obs_err, exp_err);
    send_byte(8'h29, 1'b0);
    checkpoint("after_timeout");

    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A});
    checkpoint("pause");

    send_seq('{8'hAA, 8'hFA, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C});
    checkpoint("typematic");

    // Break prefix is pending when reset hits mid-frame; it must not survive.
    send_byte(8'hF0, 1'b0);
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 4);
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk_outputs_zero("midframe_reset");
    reset = 1'b0;
    model_clear();
    lm_valid = 0;
    repeat (10) @(negedge clk_sys);
    send_byte(8'h29, 1'b0);
    checkpoint("after_reset");

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1: b = 8'hE0;
        2, 3: b = 8'hF0;
        4:    b = 8'hE1;
        5:    b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: begin
          b = 8'($urandom_range(1, 8'h83));
          if ($urandom_range(0, 3) == 0) b = 8'h1C;
        end
      endcase
      send_byte(b, $urandom_range(0, 7) == 0);
    end
    checkpoint("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
